// File: rtl/fdiv_param.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_param
// Purpose  : Parameterised binary floating-point divider. Radix-2 restoring
//            mantissa division (MAN_W+3 iterations) followed by one normalise
//            cycle; specials resolved without iterating. Subnormals in and
//            out are flushed to signed zero.
// Options  : FDIV_PARAM_RNE_EN - round to nearest, ties to even
//            (undefined: truncate toward zero, same latency)
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dispatch,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           op,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] q,
  output logic [TAG_W-1:0]     q_tag,
  output logic                 invalid,
  output logic                 divzero
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW  = EXP_W + 2;
  localparam int NIT = MAN_W + 3;
  localparam int CW  = $clog2(NIT);

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic [W-1:0]  ONE_W  = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0]  QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CW-1:0] LAST   = CW'(NIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

  // state and datapath registers
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MAN_W+1:0]       rem_q, rem_d;
  logic [MAN_W:0]         div_q, div_d;
  logic [NIT-1:0]         quo_q, quo_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   spec_q, spec_d;
  logic [W-1:0]           spec_word_q, spec_word_d;
  logic                   spec_inv_q, spec_inv_d;
  logic                   spec_dz_q, spec_dz_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [W-1:0]           q_q, q_d;
  logic [TAG_W-1:0]       q_tag_q, q_tag_d;
  logic                   invalid_q, invalid_d;
  logic                   divzero_q, divzero_d;

  // operand decode
  logic [W-1:0]           x, y;
  logic [EXP_W-1:0]       xe, ye;
  logic [MAN_W-1:0]       xf, yf;
  logic                   x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic                   res_sign, accept;

  // special-case resolution
  logic                   sp_hit, sp_inv, sp_dz;
  logic [W-1:0]           sp_word;

  // one restoring iteration
  logic [MAN_W+2:0]       trial;
  logic                   q_bit;
  logic [MAN_W+1:0]       rem_next;

  // normalise / round / range
  logic [MAN_W-1:0]       frac_pre, frac;
  logic signed [EW-1:0]   e_n, e_r;
  logic                   rnd_inc, rnd_carry;
  logic [W-1:0]           norm_word;
`ifdef FDIV_PARAM_RNE_EN
  logic                   rnd_g, rnd_s;
`endif

  assign accept = dispatch & ~busy_q;

  // map op onto a dividend x and divisor y
  always_comb begin
    x = a;
    y = b;
    case (op)
      2'b01:   x = ONE_W;
      2'b10:   begin x = b; y = a; end
      default: ;
    endcase
  end

  assign xe = x[W-2:MAN_W];
  assign ye = y[W-2:MAN_W];
  assign xf = x[MAN_W-1:0];
  assign yf = y[MAN_W-1:0];
  // a zero exponent field covers true zeros and flushed subnormals
  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (&xe) & ~(|xf);
  assign y_inf  = (&ye) & ~(|yf);
  assign x_nan  = (&xe) & (|xf);
  assign y_nan  = (&ye) & (|yf);
  assign res_sign = (op == 2'b11) ? 1'b0 : (x[W-1] ^ y[W-1]);

  // classify operand pairs whose result needs no iteration
  always_comb begin
    sp_hit  = 1'b1;
    sp_inv  = 1'b0;
    sp_dz   = 1'b0;
    sp_word = '0;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      sp_word = QNAN_W;
      sp_inv  = 1'b1;
    end else if (x_inf) begin
      sp_word = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (y_zero) begin
      sp_word = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_dz   = 1'b1;
    end else if (x_zero || y_inf) begin
      sp_word = {res_sign, {(W-1){1'b0}}};
    end else begin
      sp_hit  = 1'b0;
    end
  end

  assign trial    = {1'b0, rem_q} - {2'b00, div_q};
  assign q_bit    = ~trial[MAN_W+2];
  assign rem_next = q_bit ? trial[MAN_W+1:0] : rem_q;

  // normalise the quotient, round, and apply exponent range limits
  always_comb begin
    if (quo_q[NIT-1]) begin
      frac_pre = quo_q[NIT-2:2];
      e_n      = exp_q;
    end else begin
      frac_pre = quo_q[NIT-3:1];
      e_n      = exp_q - E_ONE;
    end
`ifdef FDIV_PARAM_RNE_EN
    if (quo_q[NIT-1]) begin
      rnd_g = quo_q[1];
      rnd_s = quo_q[0] | (|rem_q);
    end else begin
      rnd_g = quo_q[0];
      rnd_s = |rem_q;
    end
    rnd_inc = rnd_g & (rnd_s | frac_pre[0]);
`else
    rnd_inc = 1'b0;
`endif
    // an all-ones fraction rounding up wraps to zero and bumps the exponent
    rnd_carry = rnd_inc & (&frac_pre);
    frac      = frac_pre + {{(MAN_W-1){1'b0}}, rnd_inc};
    e_r       = rnd_carry ? (e_n + E_ONE) : e_n;
    if (e_r >= EMAX) begin
      norm_word = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_r <= 0) begin
      norm_word = {sign_q, {(W-1){1'b0}}};
    end else begin
      norm_word = {sign_q, e_r[EXP_W-1:0], frac};
    end
  end

  // next-state and register-update logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    tag_d       = tag_q;
    spec_d      = spec_q;
    spec_word_d = spec_word_q;
    spec_inv_d  = spec_inv_q;
    spec_dz_d   = spec_dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    q_d         = q_q;
    q_tag_d     = q_tag_q;
    invalid_d   = invalid_q;
    divzero_d   = divzero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tag_d       = tag_in;
          sign_d      = res_sign;
          busy_d      = 1'b1;
          spec_d      = sp_hit;
          spec_word_d = sp_word;
          spec_inv_d  = sp_inv;
          spec_dz_d   = sp_dz;
          if (sp_hit) begin
            // specials skip the iterations and retire on the next edge
            state_d = NORM;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = {1'b0, 1'b1, xf};
            div_d   = {1'b1, yf};
            quo_d   = '0;
            exp_d   = $signed({2'b00, xe}) - $signed({2'b00, ye}) + BIAS;
          end
        end
      end
      CALC: begin
        quo_d = {quo_q[NIT-2:0], q_bit};
        rem_d = rem_next << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = NORM;
        end
      end
      NORM: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        q_tag_d = tag_q;
        if (spec_q) begin
          q_d       = spec_word_q;
          invalid_d = spec_inv_q;
          divzero_d = spec_dz_q;
        end else begin
          q_d       = norm_word;
          invalid_d = 1'b0;
          divzero_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      tag_q       <= '0;
      spec_q      <= 1'b0;
      spec_word_q <= '0;
      spec_inv_q  <= 1'b0;
      spec_dz_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      q_q         <= '0;
      q_tag_q     <= '0;
      invalid_q   <= 1'b0;
      divzero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      tag_q       <= tag_d;
      spec_q      <= spec_d;
      spec_word_q <= spec_word_d;
      spec_inv_q  <= spec_inv_d;
      spec_dz_q   <= spec_dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      q_q         <= q_d;
      q_tag_q     <= q_tag_d;
      invalid_q   <= invalid_d;
      divzero_q   <= divzero_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign q       = q_q;
  assign q_tag   = q_tag_q;
  assign invalid = invalid_q;
  assign divzero = divzero_q;

endmodule
`default_nettype wire

// File: doc/fdiv_param.md
FDIV_PARAM -- requirements
Module: fdiv_param

Interface
REQ-001 SHALL provide parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL provide parameter MAN_W, default 23, stored fraction width; the operand width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL provide parameter TAG_W, default 4, width of the request tag carried with each operation.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: dispatch in 1 start request; a in W dividend; b in W divisor; op in 2 mode; tag_in in TAG_W request tag.
REQ-007 SHALL have ports: busy out 1 operation in flight; done out 1 result-valid pulse; q out W result; q_tag out TAG_W tag of q; invalid out 1 invalid-operation flag; divzero out 1 divide-by-zero flag.

Function
REQ-008 SHALL sample a, b, op and tag_in on the rising edge where dispatch=1 and busy=0; dispatch while busy=1 SHALL be ignored and not queued.
REQ-009 SHALL implement op: 00 a/b; 01 1.0/b (a ignored); 10 b/a; 11 |a/b| (result sign forced to 0).
REQ-010 SHALL use FSM states IDLE, CALC, NORM: IDLE->CALC on accepted non-special dispatch; CALC runs MAN_W+3 radix-2 restoring iterations; CALC->NORM; NORM->IDLE.
REQ-011 SHALL register q, q_tag and flags and pulse done for exactly one cycle on the NORM->IDLE edge, i.e. MAN_W+4 cycles after the dispatch edge (27 cycles at default).
REQ-012 SHALL resolve special operands in IDLE without entering CALC, pulsing done one cycle after the dispatch edge.
REQ-013 SHALL flush subnormal inputs to signed zero and SHALL flush subnormal or underflowed results to signed zero.
REQ-014 SHALL return canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0) with invalid=1 for 0/0, inf/inf or any NaN operand.
REQ-015 SHALL return signed infinity with divzero=1 for finite nonzero / 0.
REQ-016 SHALL return signed infinity for inf/finite and for exponent overflow, and signed zero for finite/inf, with both flags 0.
REQ-017 SHALL compute the result sign as sign(a) XOR sign(b) except in op 11 and for NaN results.
REQ-018 SHALL compute the result exponent as ea-eb+bias in EXP_W+2 bit signed arithmetic before range checks.
REQ-019 SHALL normalise in NORM by a single left shift when the quotient MSB is 0, decrementing the exponent.
REQ-020 SHALL hold busy=1 from the edge after acceptance until the edge that raises done; busy and done SHALL never both be 1.
REQ-021 SHALL hold q, q_tag and flags stable from a done pulse until the next done pulse.
REQ-022 SHALL accept a new dispatch in the same cycle that done=1, giving back-to-back operation.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, q=0, q_tag=0, invalid=0, divzero=0, regardless of clk.
REQ-024 SHALL abandon any in-flight operation on reset without producing done.
REQ-025 SHALL ignore dispatch during reset and SHALL accept dispatch from the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with FDIV_PARAM_RNE_EN defined, round to nearest, ties to even, using guard, round and sticky bits (sticky = nonzero final remainder), with mantissa carry-out incrementing the exponent.
REQ-027 SHALL, without FDIV_PARAM_RNE_EN, truncate toward zero with identical latency.

Verification
REQ-028 SHALL verify default params: a=3f800000, b=3f000000, op=00 -> q=40000000 after 27 cycles, flags 0, q_tag=tag_in.
REQ-029 SHALL verify a=3f800000, b=40400000 -> q=3eaaaaab with FDIV_PARAM_RNE_EN, 3eaaaaaa without.
REQ-030 SHALL verify specials: 3f800000/00000000 -> 7f800000 with divzero=1; 00000000/00000000 -> 7fc00000 with invalid=1; each done one cycle after dispatch.
REQ-031 SHALL verify ops: op=01, b=40000000 -> 3f000000; op=10, a=40000000, b=3f800000 -> 3f000000; op=11, a=bf800000, b=3f800000 -> 3f800000.
REQ-032 SHALL verify a second dispatch while busy is ignored (one done, first tag), and that back-to-back dispatch on the done cycle is accepted.
REQ-033 SHALL verify that rst_n pulled low mid-CALC yields outputs at zero, no done pulse, and a correct result on the next dispatch.
